// File: rtl/memory_tank_line_if.sv
// memory_tank_line_if: request, serial data and status bundle between main control and one tank
interface memory_tank_line_if #(
  parameter int ADDR_W = 5
);
  logic              r2_mib;
  logic [ADDR_W-1:0] r2_addr;
  logic              r2_long;
  logic              r2_clr_req;
  logic              r2_wr_req;
  logic              r2_rd_req;
  logic              r2_busy;
  logic              r2_done;
  logic              r2_mob;
  logic              r2_mob_valid;
  logic              r2_word_start;
  logic [ADDR_W-1:0] r2_slot;
  logic              monitor;
  modport master (
    output r2_mib, r2_addr, r2_long, r2_clr_req, r2_wr_req, r2_rd_req,
    input  r2_busy, r2_done, r2_mob, r2_mob_valid, r2_word_start, r2_slot, monitor
  );
  modport slave (
    input  r2_mib, r2_addr, r2_long, r2_clr_req, r2_wr_req, r2_rd_req,
    output r2_busy, r2_done, r2_mob, r2_mob_valid, r2_word_start, r2_slot, monitor
  );
endinterface

// File: rtl/memory_tank_line.sv
// memory_tank_line: serial circulating-store tank with addressed short/long-word transfer sequencer
module memory_tank_line #(
  parameter int SLOT_BITS = 18,
  parameter int SLOTS     = 32,
  parameter int ADDR_W    = 5
) (
  input logic               r2_clk,
  input logic               r2_rst_n,
  memory_tank_line_if.slave tank
);
  localparam int BIT_W = $clog2(SLOT_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  typedef enum logic [1:0] {OP_CLR, OP_WR, OP_RD} op_t;
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d, slot_q, slot_d, end_slot;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic long_q, long_d;
  logic [SLOTS-1:0][SLOT_BITS-1:0] mem_q;
  logic line_out, hit, last, act, rd_act, store_bit, any_req;
  logic mob_q, mob_valid_q, mon_q;
  // free-running bit/slot position: the bit emerging this cycle
  always_comb begin
    bit_d  = bit_q == LAST_BIT ? '0 : bit_q + 1'b1;
    slot_d = bit_q != LAST_BIT ? slot_q : slot_q == LAST_SLOT ? '0 : slot_q + 1'b1;
  end
  // transfer window: the matching WAIT cycle is already the first transfer bit
  always_comb begin
    line_out  = mem_q[slot_q][bit_q];
    end_slot  = long_q ? (tgt_q | ADDR_W'(1)) : tgt_q;
    hit       = slot_q == tgt_q && bit_q == '0;
    last      = slot_q == end_slot && bit_q == LAST_BIT;
    act       = state_q == XFER || (state_q == WAIT && hit);
    rd_act    = act && op_q == OP_RD;
    store_bit = (!act || op_q == OP_RD) ? line_out :
                (op_q == OP_WR && bit_q != LAST_BIT) ? tank.r2_mib : 1'b0;
    any_req   = tank.r2_clr_req | tank.r2_wr_req | tank.r2_rd_req;
  end
  // sequencer: requests are only looked at in IDLE, clear beats write beats read
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    long_d  = long_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = WAIT;
        op_d    = tank.r2_clr_req ? OP_CLR : tank.r2_wr_req ? OP_WR : OP_RD;
        long_d  = tank.r2_long;
        tgt_d   = tank.r2_long ? {tank.r2_addr[ADDR_W-1:1], 1'b0} : tank.r2_addr;
      end
      WAIT:    state_d = hit ? XFER : WAIT;
      XFER:    state_d = last ? DONE : XFER;
      default: state_d = IDLE;
    endcase
  end
  // state, storage and registered outputs; reset wipes the whole line
  always_ff @(posedge r2_clk) begin
    if (!r2_rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_CLR;
      tgt_q       <= '0;
      long_q      <= 1'b0;
      bit_q       <= '0;
      slot_q      <= '0;
      mem_q       <= '0;
      mob_q       <= 1'b0;
      mob_valid_q <= 1'b0;
      mon_q       <= 1'b0;
    end else begin
      state_q              <= state_d;
      op_q                 <= op_d;
      tgt_q                <= tgt_d;
      long_q               <= long_d;
      bit_q                <= bit_d;
      slot_q               <= slot_d;
      mem_q[slot_q][bit_q] <= store_bit;
      mob_q                <= rd_act & line_out;
      mob_valid_q          <= rd_act;
      mon_q                <= line_out;
    end
  end
  assign tank.r2_busy       = state_q != IDLE;
  assign tank.r2_done       = state_q == DONE;
  assign tank.r2_mob        = mob_q;
  assign tank.r2_mob_valid  = mob_valid_q;
  assign tank.r2_word_start = bit_q == '0;
  assign tank.r2_slot       = slot_q;
  assign tank.monitor       = mon_q;
endmodule

// File: tb/tb_memory_tank_line.sv
// tb_memory_tank_line: randomized scoreboard bench for memory_tank_line against a word-array tank model
module tb_memory_tank_line;
  localparam int SB  = 18;
  localparam int NS  = 32;
  localparam int REV = SB * NS;
  typedef struct {
    int          acc;
    int          dcyc;
    int          op;
    int          tgt;
    bit          lng;
    logic [35:0] data;
  } op_rec_t;
  typedef struct {
    int   c;
    logic b;
  } bit_rec_t;
  logic clk = 0;
  logic rst_n = 0;
  memory_tank_line_if #(.ADDR_W(5)) tif();
  memory_tank_line #(.SLOT_BITS(SB), .SLOTS(NS), .ADDR_W(5)) dut (
    .r2_clk  (clk),
    .r2_rst_n(rst_n),
    .tank    (tif)
  );
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pos = 0;
  int last_done = -1;
  int wstart = 0;
  int wlen = 0;
  logic [35:0] wbits = '0;
  logic [16:0] mem[NS];
  op_rec_t dq[$];
  bit_rec_t bq[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pos <= !rst_n ? 0 : (pos + 1) % REV;
  end
  always @(negedge clk)
    tif.r2_mib = (cyc >= wstart && cyc < wstart + wlen) ? wbits[cyc - wstart] : 1'($urandom);
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, a, e);
    end
  endtask
  task automatic miss(input string n, input int e);
    tests++;
    fails++;
    $display("FAIL %s: expected by cycle %0d, not seen at cycle %0d", n, e, cyc);
  endtask
  function automatic logic model_bit(input int p);
    int s = (p / SB) % NS;
    int b = p % SB;
    return b == SB - 1 ? 1'b0 : mem[s][b];
  endfunction
  function automatic void apply(input op_rec_t d);
    if (d.op == 0) begin
      mem[d.tgt] = '0;
      if (d.lng) mem[d.tgt + 1] = '0;
    end else if (d.op == 1) begin
      mem[d.tgt] = d.data[16:0];
      if (d.lng) mem[d.tgt + 1] = d.data[34:18];
    end
  endfunction
  initial begin
    op_rec_t d;
    bit_rec_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("word_start", int'(tif.r2_word_start), int'(pos % SB == 0));
        chk("slot", int'(tif.r2_slot), pos / SB);
        if (dq.size() == 0) chk("busy_idle", int'(tif.r2_busy), 0);
        else chk("busy", int'(tif.r2_busy), int'(cyc > dq[0].acc));
        if (!tif.r2_busy) chk("monitor", int'(tif.monitor), int'(model_bit((pos + REV - 1) % REV)));
        if (tif.r2_mob_valid) begin
          if (bq.size() == 0) chk("mob_valid_unexpected", int'(tif.r2_mob_valid), 0);
          else begin
            e = bq.pop_front();
            chk("mob_cycle", cyc, e.c);
            chk("mob_bit", int'(tif.r2_mob), int'(e.b));
          end
        end
        while (bq.size() > 0 && bq[0].c < cyc) begin
          e = bq.pop_front();
          miss("mob_missing", e.c);
        end
        if (tif.r2_done) begin
          if (dq.size() == 0) chk("done_unexpected", int'(tif.r2_done), 0);
          else begin
            d = dq.pop_front();
            chk("done_cycle", cyc, d.dcyc);
            apply(d);
            last_done = cyc;
          end
        end
        while (dq.size() > 0 && dq[0].dcyc < cyc) begin
          d = dq.pop_front();
          apply(d);
          last_done = cyc;
          miss("done_missing", d.dcyc);
        end
      end
    end
  end
  task automatic do_op(input logic [2:0] req, input int addr, input bit lng,
                       input logic [35:0] data, input int at_pos);
    op_rec_t d;
    int n = 0;
    int len = lng ? 2 * SB : SB;
    int st;
    do begin
      @(negedge clk);
      n++;
    end while (!(dq.size() == 0 && cyc > last_done && (at_pos < 0 || pos == at_pos)) && n < 3000);
    if (n >= 3000) begin
      miss("issue_wait", cyc);
      return;
    end
    d.op   = req[2] ? 0 : req[1] ? 1 : 2;
    d.lng  = lng;
    d.tgt  = lng ? (addr & ~1) : addr;
    d.data = data;
    d.acc  = cyc;
    st     = cyc + ((d.tgt * SB - pos - 1) % REV + REV) % REV + 1;
    d.dcyc = st + len;
    dq.push_back(d);
    if (d.op == 2)
      for (int i = 0; i < len; i++) bq.push_back('{st + 1 + i, model_bit(d.tgt * SB + i)});
    if (d.op == 1) begin
      wbits  = data;
      wstart = st;
      wlen   = len;
    end
    tif.r2_clr_req = req[2];
    tif.r2_wr_req  = req[1];
    tif.r2_rd_req  = req[0];
    tif.r2_addr    = 5'(addr);
    tif.r2_long    = lng;
    @(negedge clk);
    tif.r2_clr_req = 1'b0;
    tif.r2_wr_req  = 1'b0;
    tif.r2_rd_req  = 1'b0;
    tif.r2_addr    = 5'($urandom);
    tif.r2_long    = 1'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((dq.size() > 0 || bq.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) miss("idle_wait", cyc);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    dq.delete();
    bq.delete();
    wlen = 0;
    foreach (mem[i]) mem[i] = '0;
    @(negedge clk);
    chk("rst_busy", int'(tif.r2_busy), 0);
    chk("rst_done", int'(tif.r2_done), 0);
    chk("rst_mob", int'(tif.r2_mob), 0);
    chk("rst_mob_valid", int'(tif.r2_mob_valid), 0);
    chk("rst_monitor", int'(tif.monitor), 0);
    chk("rst_slot", int'(tif.r2_slot), 0);
    chk("rst_word_start", int'(tif.r2_word_start), 1);
    rst_n = 1'b1;
  endtask
  initial begin
    #950000;
    $display("FAIL watchdog: run did not finish at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int dc;
    int n;
    logic [63:0] r;
    tif.r2_addr    = '0;
    tif.r2_long    = 1'b0;
    tif.r2_clr_req = 1'b0;
    tif.r2_wr_req  = 1'b0;
    tif.r2_rd_req  = 1'b0;
    do_reset();
    repeat (REV) @(negedge clk);
    do_op(3'b010, 5, 0, 36'h15A5A, -1);
    do_op(3'b001, 5, 0, '0, -1);
    do_op(3'b010, 7, 1, {1'b1, 17'h01234, 1'b1, 17'h0F0F0}, -1);
    do_op(3'b001, 6, 1, '0, -1);
    do_op(3'b001, 8, 0, '0, -1);
    do_op(3'b100, 5, 0, '0, -1);
    do_op(3'b001, 5, 0, '0, -1);
    do_op(3'b010, 3, 0, 36'h3ABCD, -1);
    do_op(3'b111, 3, 0, 36'h1FFFF, -1);
    do_op(3'b001, 3, 0, '0, -1);
    do_op(3'b001, 2, 0, '0, 40);
    dc = dq.size() > 0 ? dq[0].dcyc : cyc;
    repeat (30) begin
      @(negedge clk);
      tif.r2_wr_req = 1'b1;
    end
    @(negedge clk);
    tif.r2_wr_req = 1'b0;
    n = 0;
    while (cyc != dc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tif.r2_wr_req = 1'b1;
    @(negedge clk);
    tif.r2_wr_req = 1'b0;
    wait_idle();
    do_op(3'b010, 10, 0, 36'h1FFFF, -1);
    n = 0;
    while (cyc != wstart + 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    do_reset();
    repeat (5) @(negedge clk);
    do_op(3'b001, 10, 0, '0, -1);
    for (int i = 0; i < 14; i++) begin
      r = {$urandom, $urandom};
      do_op(3'($urandom_range(1, 7)), $urandom_range(0, NS - 1), 1'($urandom), r[35:0], -1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
